immediate_narrow_packer: RTL and testbench

//  Narrowing counterpart of the 2->8 bit immediate sign extension path: accepts 8-bit signed

---
 rtl/immediate_narrow_packer_pkg.sv | 21 ++
 rtl/immediate_narrow_packer_narrow_field.sv | 31 +++
 rtl/immediate_narrow_packer.sv | 122 ++++++++++++
 tb/tb_immediate_narrow_packer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/immediate_narrow_packer_pkg.sv
// Shared widths, saturation limits and FSM state type for the narrow immediate packer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package imm_pkg;

    localparam int IN_W    = 8;
    localparam int FIELD_W = 2;
    localparam int FIELDS  = 4;
    localparam int IDX_W   = $clog2(FIELDS);
    localparam int CNT_W   = 3;

    // Largest and smallest values a signed FIELD_W-bit field can hold.
    localparam logic [FIELD_W-1:0] FIELD_MAX = 2'b01;
    localparam logic [FIELD_W-1:0] FIELD_MIN = 2'b10;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/immediate_narrow_packer_narrow_field.sv
// Narrows one signed IN_W operand to a signed FIELD_W field (saturate or truncate) and flags overflow.
// Latency: combinational, zero cycles.
// Backpressure: none; purely a function of i_data.
// Ports: i_data (signed operand in), o_field (narrowed field out), o_ovf (operand did not fit).
module narrow_field
    import imm_pkg::*;
#(
    parameter bit SATURATE = 1'b1
) (
    input  logic [IN_W-1:0]    i_data,
    output logic [FIELD_W-1:0] o_field,
    output logic               o_ovf
);

    // The operand fits when every bit from the sign bit down to the field's own
    // sign bit is identical, i.e. the upper bits are pure sign extension.
    logic [IN_W-FIELD_W:0] w_upper;
    logic                  w_fits;

    assign w_upper = i_data[IN_W-1:FIELD_W-1];
    assign w_fits  = (&w_upper) | ~(|w_upper);
    assign o_ovf   = ~w_fits;

    always_comb begin
        o_field = i_data[FIELD_W-1:0];
        if (!w_fits && SATURATE) begin
            o_field = i_data[IN_W-1] ? FIELD_MIN : FIELD_MAX;
        end
    end

endmodule

// File: rtl/immediate_narrow_packer.sv
// Packs up to FIELDS narrowed operands LSB-first into one IN_W word, with per-field overflow flags.
// Latency: Out_Valid rises the cycle after the closing operand is accepted.
// Backpressure: In_Ready drops while a finished word waits in HOLD; words are never overlapped with input.
// Ports: Clk/Rst (async active-high), In_Valid/In_Ready/In_Data/In_Last operand stream,
//        Out_Valid/Out_Ready/Out_Data/Out_Count/Out_Ovf packed word, Clr_Stats/Ovf_Count statistics.
module immediate_narrow_packer
    import imm_pkg::*;
#(
    parameter bit SATURATE = 1'b1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [IN_W-1:0]   In_Data,
    input  logic              In_Last,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [IN_W-1:0]   Out_Data,
    output logic [CNT_W-1:0]  Out_Count,
    output logic [FIELDS-1:0] Out_Ovf,
    input  logic              Clr_Stats,
    output logic [7:0]        Ovf_Count
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FIELDS - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_cnt;
    logic [IN_W-1:0]    r_acc;
    logic [FIELDS-1:0]  r_ovf;
    logic [7:0]         r_ovf_cnt;

    logic [FIELD_W-1:0] w_field;
    logic               w_ovf;
    logic               w_accept;
    logic               w_xfer;

    narrow_field #(
        .SATURATE (SATURATE)
    ) u_narrow (
        .i_data  (In_Data),
        .o_field (w_field),
        .o_ovf   (w_ovf)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_xfer      = 1'b0;
        case (r_state)
            FILL: begin
                if (In_Valid) begin
                    w_accept = 1'b1;
                    if (r_idx == LAST_IDX || In_Last) begin
                        w_state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (Out_Ready) begin
                    w_xfer      = 1'b1;
                    w_state_nxt = FILL;
                end
            end
            default: w_state_nxt = FILL;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= FILL;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_ovf   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                for (int k = 0; k < FIELDS; k++) begin
                    if (r_idx == IDX_W'(k)) begin
                        r_acc[k*FIELD_W +: FIELD_W] <= w_field;
                        r_ovf[k]                    <= w_ovf;
                    end
                end
                // Wraps to 0 after the last field; HOLD blocks further writes anyway.
                r_idx <= r_idx + 1'b1;
                r_cnt <= r_cnt + 1'b1;
            end else if (w_xfer) begin
                r_idx <= '0;
                r_cnt <= '0;
                r_acc <= '0;
                r_ovf <= '0;
            end
        end
    end

    // A clear coinciding with a counted overflow keeps that overflow, so the count restarts at 1.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_ovf_cnt <= '0;
        end else if (w_accept && w_ovf) begin
            if (Clr_Stats) begin
                r_ovf_cnt <= 8'd1;
            end else if (r_ovf_cnt != 8'hFF) begin
                r_ovf_cnt <= r_ovf_cnt + 8'd1;
            end
        end else if (Clr_Stats) begin
            r_ovf_cnt <= '0;
        end
    end

    assign In_Ready  = (r_state == FILL);
    assign Out_Valid = (r_state == HOLD);
    assign Out_Data  = r_acc;
    assign Out_Count = r_cnt;
    assign Out_Ovf   = r_ovf;
    assign Ovf_Count = r_ovf_cnt;

endmodule

// File: tb/tb_immediate_narrow_packer.sv
// Randomized and directed bench for immediate_narrow_packer, saturating and truncating builds side by side.
// Latency: expects Out_Valid one cycle after the closing operand is accepted.
// Backpressure: exercises random and long Out_Ready stalls while a word is held.
module tb_immediate_narrow_packer;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       In_Valid = 1'b0;
    logic [7:0] In_Data = '0;
    logic       In_Last = 1'b0;
    logic       Out_Ready = 1'b0;
    logic       Clr_Stats = 1'b0;

    logic       s_in_rdy, s_out_vld, t_in_rdy, t_out_vld;
    logic [7:0] s_out_dat, t_out_dat, s_ovf_cnt, t_ovf_cnt;
    logic [2:0] s_out_cnt, t_out_cnt;
    logic [3:0] s_out_ovf, t_out_ovf;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state for the word currently being built.
    int         m_n;
    logic [7:0] m_sat, m_trn;
    logic [3:0] m_ovf;
    int         m_ovf_cnt;

    always #5 Clk = ~Clk;

    immediate_narrow_packer #(.SATURATE(1'b1)) u_sat (
        .Clk(Clk), .Rst(Rst), .In_Valid(In_Valid), .In_Ready(s_in_rdy),
        .In_Data(In_Data), .In_Last(In_Last), .Out_Valid(s_out_vld), .Out_Ready(Out_Ready),
        .Out_Data(s_out_dat), .Out_Count(s_out_cnt), .Out_Ovf(s_out_ovf),
        .Clr_Stats(Clr_Stats), .Ovf_Count(s_ovf_cnt)
    );

    immediate_narrow_packer #(.SATURATE(1'b0)) u_trn (
        .Clk(Clk), .Rst(Rst), .In_Valid(In_Valid), .In_Ready(t_in_rdy),
        .In_Data(In_Data), .In_Last(In_Last), .Out_Valid(t_out_vld), .Out_Ready(Out_Ready),
        .Out_Data(t_out_dat), .Out_Count(t_out_cnt), .Out_Ovf(t_out_ovf),
        .Clr_Stats(Clr_Stats), .Ovf_Count(t_ovf_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit m_is_ovf(input logic [7:0] d);
        int v;
        v = int'($signed(d));
        return (v > 1) || (v < -2);
    endfunction

    function automatic logic [1:0] m_sat_field(input logic [7:0] d);
        int v;
        v = int'($signed(d));
        if (v > 1)  return 2'b01;
        if (v < -2) return 2'b10;
        return d[1:0];
    endfunction

    task automatic m_clear_word();
        m_n = 0; m_sat = '0; m_trn = '0; m_ovf = '0;
    endtask

    // Called at a negedge; returns at the negedge following the accepting posedge.
    task automatic push(input logic [7:0] d, input logic last, output bit closed);
        int  n;
        bit  ov;
        n = 0;
        while (!s_in_rdy && n < 100) begin
            In_Valid = 1'b0;
            @(negedge Clk);
            n++;
        end
        if (!s_in_rdy) chk("push_ready_timeout", 32'(s_in_rdy), 32'd1);
        In_Valid = 1'b1; In_Data = d; In_Last = last;
        ov = m_is_ovf(d);
        m_sat = m_sat | (8'(m_sat_field(d)) << (2 * m_n));
        m_trn = m_trn | (8'(d & 8'h03) << (2 * m_n));
        m_ovf[m_n] = ov;
        m_n++;
        if (ov) m_ovf_cnt = Clr_Stats ? 1 : ((m_ovf_cnt < 255) ? m_ovf_cnt + 1 : 255);
        else if (Clr_Stats) m_ovf_cnt = 0;
        closed = (m_n == 4) || last;
        @(negedge Clk);
        In_Valid = 1'b0; In_Last = 1'b0;
    endtask

    // Called at the negedge right after the closing operand was accepted.
    task automatic check_word(input int stall);
        logic [7:0] held;
        chk("out_vld_latency", 32'(s_out_vld), 32'd1);
        chk("out_vld_trn", 32'(t_out_vld), 32'd1);
        chk("in_rdy_hold", 32'(s_in_rdy), 32'd0);
        chk("out_dat_sat", 32'(s_out_dat), 32'(m_sat));
        chk("out_dat_trn", 32'(t_out_dat), 32'(m_trn));
        chk("out_cnt", 32'(s_out_cnt), 32'(m_n));
        chk("out_ovf_sat", 32'(s_out_ovf), 32'(m_ovf));
        chk("out_ovf_trn", 32'(t_out_ovf), 32'(m_ovf));
        chk("ovf_cnt", 32'(s_ovf_cnt), 32'(m_ovf_cnt));
        held = m_sat;
        for (int i = 0; i < stall; i++) begin
            @(negedge Clk);
            chk("stall_vld", 32'(s_out_vld), 32'd1);
            chk("stall_dat", 32'(s_out_dat), 32'(held));
            chk("stall_in_rdy", 32'(s_in_rdy), 32'd0);
        end
        Out_Ready = 1'b1;
        @(negedge Clk);
        Out_Ready = 1'b0;
        chk("post_xfer_vld", 32'(s_out_vld), 32'd0);
        chk("post_xfer_in_rdy", 32'(s_in_rdy), 32'd1);
        chk("post_xfer_dat", 32'(s_out_dat), 32'd0);
        m_clear_word();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_rdy"}, 32'(s_in_rdy), 32'd1);
        chk({tag, "_out_vld"}, 32'(s_out_vld), 32'd0);
        chk({tag, "_out_dat"}, 32'(s_out_dat), 32'd0);
        chk({tag, "_out_cnt"}, 32'(s_out_cnt), 32'd0);
        chk({tag, "_out_ovf"}, 32'(s_out_ovf), 32'd0);
        chk({tag, "_ovf_cnt"}, 32'(s_ovf_cnt), 32'd0);
    endtask

    task automatic send_word(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                             input logic [7:0] d3, input int len, input bit last_on_4, input int stall);
        logic [7:0] ops [4];
        bit closed;
        ops[0] = d0; ops[1] = d1; ops[2] = d2; ops[3] = d3;
        closed = 1'b0;
        for (int i = 0; i < len; i++) begin
            push(ops[i], (i == len - 1) && (len < 4 || last_on_4), closed);
        end
        if (closed) check_word(stall);
        else chk("word_not_closed", 32'd0, 32'd1);
    endtask

    function automatic logic [7:0] rnd_op();
        if ($urandom_range(0, 1) == 0) return 8'($signed($urandom_range(0, 3)) - 2);
        return 8'($urandom);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit closed;
        m_clear_word();
        m_ovf_cnt = 0;
        repeat (2) @(negedge Clk);
        check_reset_vals("rst_active");
        Rst = 1'b0;
        @(negedge Clk);
        check_reset_vals("rst_release");

        // Full word closed by In_Last on the 4th operand.
        send_word(8'h01, 8'hFF, 8'hFE, 8'h00, 4, 1'b1, 0);
        // Two overflows, early close: sat 09, trunc 01.
        send_word(8'h05, 8'h80, 8'h00, 8'h00, 2, 1'b1, 0);
        // Single operand.
        send_word(8'hFF, 8'h00, 8'h00, 8'h00, 1, 1'b1, 0);
        // Long stall in HOLD.
        send_word(8'h01, 8'h7F, 8'hFE, 8'h81, 4, 1'b0, 5);

        // Reset after two accepted operands discards the partial word and stats.
        push(8'h01, 1'b0, closed);
        push(8'h40, 1'b0, closed);
        Rst = 1'b1;
        #2;
        check_reset_vals("rst_mid");
        @(negedge Clk);
        Rst = 1'b0;
        m_clear_word();
        m_ovf_cnt = 0;
        @(negedge Clk);
        send_word(8'hFE, 8'h00, 8'h01, 8'hFF, 4, 1'b0, 0);

        // Randomized words.
        for (int w = 0; w < 40; w++) begin
            send_word(rnd_op(), rnd_op(), rnd_op(), rnd_op(), int'($urandom_range(1, 4)),
                      1'($urandom), int'($urandom_range(0, 3)));
        end

        // Saturate the overflow counter.
        for (int w = 0; w < 65; w++) begin
            logic [7:0] o [4];
            for (int k = 0; k < 4; k++)
                o[k] = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(2, 127)) : 8'($urandom_range(128, 253));
            send_word(o[0], o[1], o[2], o[3], 4, 1'b0, 0);
        end
        chk("ovf_cnt_saturated", 32'(s_ovf_cnt), 32'd255);

        // Clear coinciding with an overflow leaves one counted.
        Clr_Stats = 1'b1;
        push(8'h55, 1'b0, closed);
        Clr_Stats = 1'b0;
        chk("clr_with_ovf", 32'(s_ovf_cnt), 32'd1);
        // Clear alone zeroes the count.
        Clr_Stats = 1'b1;
        @(negedge Clk);
        Clr_Stats = 1'b0;
        m_ovf_cnt = 0;
        chk("clr_alone", 32'(s_ovf_cnt), 32'd0);
        push(8'h00, 1'b1, closed);
        check_word(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
